bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble). Iterates one bit per clock.
- Sits directly upstream of the seven-segment digit decoders on the board. Converts the 32-bit PC/debug value into packed BCD digits, so each decoder receives a 4-bit digit and no divider is needed.
- Uses a start/busy/done handshake. The result is held stable between conversions.

Parameters:
- WIDTH, 32, binary input width.
- DIGITS, 10, number of BCD output digits. 10 covers 2^32-1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset.
- DIN  in  WIDTH  binary value; sampled only when START is accepted.
- START  in  1  conversion request; level-sampled.
- BUSY  out  1  conversion in progress.
- DONE  out  1  one-cycle pulse; BCD/OVF updated in this cycle.
- BCD  out  4*DIGITS  packed digits; [3:0] is the ones digit, [7:4] is the tens digit, and so on.
- OVF  out  1  value did not fit in DIGITS digits.

Behaviour:
- Interface: one clock, CLK. Reset nRST is synchronous and active-low. No asynchronous logic.
- Reset (nRST=0 at an edge):
  - State goes to IDLE.
  - BUSY=0, DONE=0, BCD=0, OVF=0.
  - Shift register and bit counter cleared.
  - A reset mid-conversion aborts the conversion. No DONE is produced.
- States: IDLE, SHIFT.
- IDLE:
  - If START=1 at edge k: capture DIN into the binary shift register, clear the working BCD register, clear the sticky overflow flag, load counter=WIDTH-1, go to SHIFT.
  - BUSY=1 after edge k.
- SHIFT, each edge:
  1. Every working digit >=5 gets +3 (4-bit result).
  2. Then {work_bcd, bin} shifts left by 1.
  3. The bit shifted out of the top digit's MSB sets the sticky overflow flag.
  4. When counter=0 on this edge: BCD<=shifted result, OVF<=sticky|carry-out, DONE<=1, BUSY<=0, go to IDLE. Otherwise decrement the counter.
- Latency: START accepted at edge k gives DONE=1 and a valid BCD in the cycle following edge k+WIDTH. That is 32 cycles for default parameters.
- DONE is high for exactly one cycle. It is never high while BUSY=1.
- START while BUSY=1 is ignored. It is neither queued nor latched.
- START held high continuously: a new conversion is accepted on the edge where DONE=1 is visible (state is IDLE). Back-to-back period is WIDTH+1 cycles.
- BCD and OVF change only at the completion edge. They hold their previous values throughout a conversion, so the display never shows partial results.
- DIN changes after acceptance have no effect on the running conversion.
- Arithmetic:
  - Working digits are 4-bit unsigned. The adjust is applied before the shift, never after the final shift.
  - With DIGITS too small for the value, BCD holds the low DIGITS decimal digits (value mod 10^DIGITS) and OVF=1.
- DIN=0: converts normally, BCD=0, OVF=0.

Optional Feature:
- Macro: BIN2BCD_LZB_EN.
- Defined: adds output BLANK [DIGITS-1:0].
  - Bit i=1 when digit i and all higher digits are zero, for i>=1.
  - Bit 0 is always 0.
  - BLANK is registered, updated on the same edge as BCD, and reset to 0.
  - Downstream decoders force their segments off where BLANK is set.
- Not defined: no BLANK port, no related logic. Everything else is identical.

Decomposition:
- Shared package bin2bcd_pkg:
  - BCD_DIGIT_W=4, ADJ_THRESH=4'd5, ADJ_ADD=4'd3.
  - State enum (IDLE, SHIFT).
- Sub-module bcd_digit_adj: combinational, 4-bit in and 4-bit out, adds 3 when the input is >=5. Instantiated DIGITS times via generate.
- Counter width is $clog2(WIDTH).

Test Plan:
- DIN=59, START pulse at edge k -> BUSY=1 for edges k..k+31; DONE=1 after edge k+32; BCD[7:0]=8'h59, upper digits 0, OVF=0.
- DIN=32'hFFFFFFFF -> BCD=40'h4294967295, OVF=0. Repeat with DIGITS=4 -> BCD=16'h7295, OVF=1.
- Conversion of 123 in progress; START pulsed with DIN=999 at cycle 10 -> ignored; single DONE with BCD=12'h123. BCD holds the previous value (0) until then.
- nRST=0 at cycle 15 of a conversion -> next cycle BUSY=0, BCD=0, no DONE. A fresh START with DIN=7 then gives BCD=4'h7 after 32 cycles.
- START held high with DIN=5, 10, 15 stepping at each DONE -> DONE every 33 cycles; BCD sequence 5, 10, 15.
- BIN2BCD_LZB_EN defined, DIN=0 -> BLANK=10'b1111111110. DIN=40 -> BLANK=10'b1111111100.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and state type for the sequential binary-to-BCD converter
package bin2bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done conversion bus; BLANK present when BIN2BCD_LZB_EN is defined
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);

  logic [WIDTH-1:0]    DIN;
  logic                START;
  logic                BUSY;
  logic                DONE;
  logic [4*DIGITS-1:0] BCD;
  logic                OVF;
`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0]   BLANK;

  modport master (output DIN, START, input BUSY, DONE, BCD, OVF, BLANK);
  modport slave  (input DIN, START, output BUSY, DONE, BCD, OVF, BLANK);
`else
  modport master (output DIN, START, input BUSY, DONE, BCD, OVF);
  modport slave  (input DIN, START, output BUSY, DONE, BCD, OVF);
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 adjust of one BCD digit ahead of the dabble shift
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock double-dabble converter with held result
// Optional leading-zero blanking output enabled by BIN2BCD_LZB_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input logic          CLK,
  input logic          nRST,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [BCD_W-1:0]   work_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_w;
  logic [BCD_W-1:0]   work_d;
  logic [WIDTH-1:0]   bin_d;
  logic               carry_w;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj_w[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits and binary shift as one wide register; the bit leaving the top digit is overflow.
  assign carry_w = adj_w[BCD_W-1];
  assign work_d  = {adj_w[BCD_W-2:0], bin_q[WIDTH-1]};
  assign bin_d   = bin_q << 1;

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              hi_zero;

  always_comb begin
    blank_d = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero    = hi_zero && (work_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_d[i] = hi_zero;
    end
  end

  assign bus.BLANK = blank_q;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BIN2BCD_LZB_EN
      blank_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            bin_q    <= bus.DIN;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q    <= bin_d;
          work_q   <= work_d;
          sticky_q <= sticky_q | carry_w;
          if (cnt_q == '0) begin
            bcd_q   <= work_d;
            ovf_q   <= sticky_q | carry_w;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef BIN2BCD_LZB_EN
            blank_q <= blank_d;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.BCD  = bcd_q;
  assign bus.OVF  = ovf_q;

endmodule
